mips_mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port MIPS data memory, a 256-word memory with combinational read and posedge write. It sits between the memory and two masters: requester 0 is the core load/store path, requester 1 is the debug/loader port. It serialises their accesses with a req/ack handshake and a registered fixed-latency response. It owns the memory's `address`, `write_data`, `mem_write` and `mem_read` inputs exclusively.

---
 rtl/mips_mem_arb_pkg.sv | 17 +
 rtl/mips_arb_pick2.sv | 31 +++
 rtl/mips_mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_arb_pkg.sv
// Shared types and default sizes for the MIPS data-memory arbiter.
// Contents: state enum, default DEPTH/DATA_W/ADDR_W, requester-id type.
package mips_mem_arb_pkg;

  localparam int DEPTH_DEF  = 256;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/mips_arb_pick2.sv
// Combinational two-way pick: (req0, req1, last) -> (gnt_vld, gnt_id).
// MEM_ARB_ROUND_ROBIN_EN: tie goes to the requester not granted last.
module mips_arb_pick2
  import mips_mem_arb_pkg::*;
(
  input  logic    req0,
  input  logic    req1,
  input  req_id_t last,
  output logic    gnt_vld,
  output req_id_t gnt_id
);

  always_comb begin
    gnt_vld = req0 | req1;
    gnt_id  = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (req0 && req1)
      gnt_id = ~last;
    else
      gnt_id = req1;
`else
    gnt_id = req1 & ~req0;
`endif
  end

`ifndef MEM_ARB_ROUND_ROBIN_EN
  logic unused_last;
  assign unused_last = last;
`endif

endmodule

// File: rtl/mips_mem_arbiter.sv
// Two-requester arbiter/sequencer for the 256-word MIPS data memory.
// Ports: clk, rst (async, active high); req/we/addr/wdata in and
// ack/err/rdata out per requester; mem_* drive the memory port.
// MEM_ARB_ROUND_ROBIN_EN: round-robin tie break, else req0 wins.
module mips_mem_arbiter
  import mips_mem_arb_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,
  output logic              ack1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_t state_q, state_d;

  req_id_t           id_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic              gnt_vld;
  req_id_t           gnt_id;
  req_id_t           last;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              oob;
  logic              grant;
  logic [DATA_W-1:0] cap;

  mips_arb_pick2 u_pick (
    .req0    (req0),
    .req1    (req1),
    .last    (last),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  assign sel_we    = gnt_id ? we1    : we0;
  assign sel_addr  = gnt_id ? addr1  : addr0;
  assign sel_wdata = gnt_id ? wdata1 : wdata0;
  assign oob       = sel_addr >= ADDR_W'(DEPTH);
  assign grant     = (state_q == IDLE) && gnt_vld;
  assign cap       = we_q ? '0 : mem_read_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  req_id_t last_q;

  // Reset as "last grant = 1" so the first tie goes to requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_q <= 1'b1;
    else if (grant)
      last_q <= gnt_id;
  end

  assign last = last_q;
`else
  assign last = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    ack0           = 1'b0;
    ack1           = 1'b0;
    err0           = 1'b0;
    err1           = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld)
          state_d = oob ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_write      = we_q;
        mem_read       = ~we_q;
        mem_address    = addr_q;
        mem_write_data = wdata_q;
        state_d        = RESP;
      end
      RESP: begin
        ack0    = ~id_q;
        ack1    = id_q;
        err0    = ~id_q & err_q;
        err1    = id_q & err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // rdata is cleared for write and error responses so it never
  // carries stale read data alongside an ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (grant) begin
        id_q    <= gnt_id;
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        err_q   <= oob;
        if (oob) begin
          if (gnt_id)
            rdata1_q <= '0;
          else
            rdata0_q <= '0;
        end
      end
      if (state_q == ACCESS) begin
        if (id_q)
          rdata1_q <= cap;
        else
          rdata0_q <= cap;
      end
    end
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed self-checking bench for mips_mem_arbiter.
// Includes a 256-word comb-read/posedge-write memory model.
module tb_mips_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write, mem_read;

  logic [31:0] mem [0:255];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mips_mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .req0           (req0),
    .we0            (we0),
    .addr0          (addr0),
    .wdata0         (wdata0),
    .req1           (req1),
    .we1            (we1),
    .addr1          (addr1),
    .wdata1         (wdata1),
    .ack0           (ack0),
    .err0           (err0),
    .rdata0         (rdata0),
    .ack1           (ack1),
    .err1           (err1),
    .rdata1         (rdata1),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data)
  );

  always @(posedge clk)
    if (mem_write)
      mem[mem_address[7:0]] <= mem_write_data;

  assign mem_read_data = mem[mem_address[7:0]];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // lat counts negedges from request until ack (10 = never acked).
  task automatic run_req(input int id, input logic we,
                         input logic [31:0] addr,
                         input logic [31:0] wd,
                         output int lat, output logic [31:0] rd,
                         output logic er, output int nw,
                         output int nr);
    lat = 0;
    nw  = 0;
    nr  = 0;
    rd  = '0;
    er  = 1'b0;
    if (id == 0) begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      nw += int'(mem_write);
      nr += int'(mem_read);
      if ((id == 0 && ack0) || (id == 1 && ack1)) begin
        rd = (id == 1) ? rdata1 : rdata0;
        er = (id == 1) ? err1 : err0;
        break;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int          lat, nw, nr, got, cyc, acks;
    logic [31:0] rd;
    logic        er;
    int          exp_id;

    for (int i = 0; i < 256; i++)
      mem[i] = 32'hA500_0000 | i;
    rst = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ack", {30'd0, ack0, ack1}, 32'd0);
    check("rst_err", {30'd0, err0, err1}, 32'd0);
    check("rst_rdata", rdata0 | rdata1, 32'd0);
    check("rst_mem", {30'd0, mem_write, mem_read}, 32'd0);
    check("rst_maddr", mem_address | mem_write_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_req(0, 1'b1, 32'd5, 32'hDEAD_BEEF, lat, rd, er, nw, nr);
    check("wr_lat", lat, 2);
    check("wr_nwrite", nw, 1);
    check("wr_err", {31'd0, er}, 32'd0);
    check("wr_rdata", rd, 32'd0);
    run_req(0, 1'b0, 32'd5, 32'd0, lat, rd, er, nw, nr);
    check("rd_lat", lat, 2);
    check("rd_nread", nr, 1);
    check("rd_data", rd, 32'hDEAD_BEEF);

    run_req(1, 1'b0, 32'd256, 32'd0, lat, rd, er, nw, nr);
    check("oob_lat", lat, 1);
    check("oob_err", {31'd0, er}, 32'd1);
    check("oob_rdata", rd, 32'd0);
    check("oob_strobes", nw + nr, 0);
    run_req(1, 1'b0, 32'hFFFF_FFFF, 32'd0, lat, rd, er, nw, nr);
    check("oob_max_err", {31'd0, er}, 32'd1);
    run_req(1, 1'b0, 32'd255, 32'd0, lat, rd, er, nw, nr);
    check("edge_lat", lat, 2);
    check("edge_err", {31'd0, er}, 32'd0);
    check("edge_data", rd, 32'hA500_00FF);

    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd2;
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (ack0 || ack1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_id = got % 2;
`else
        exp_id = 0;
`endif
        check($sformatf("tie_id%0d", got), {31'd0, ack1}, exp_id);
        if (ack1)
          check("tie_rdata1", rdata1, 32'hA500_0002);
        else
          check("tie_rdata0", rdata0, 32'hA500_0001);
        got++;
      end
    end
    check("tie_count", got, 4);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);

    req0 = 1'b1; we0 = 1'b1; addr0 = 32'd7; wdata0 = 32'h1234_5678;
    @(negedge clk);
    check("rstacc_mw", {31'd0, mem_write}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstacc_mw_drop", {31'd0, mem_write}, 32'd0);
    check("rstacc_outs", mem_address | rdata0 | rdata1, 32'd0);
    req0 = 1'b0;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      acks += int'(ack0) + int'(ack1);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      acks += int'(ack0) + int'(ack1);
    end
    check("rstacc_noack", acks, 0);
    run_req(0, 1'b0, 32'd7, 32'd0, lat, rd, er, nw, nr);
    check("rstacc_prior", rd, 32'hA500_0007);

    req0 = 1'b1; we0 = 1'b0; addr0 = 32'd9;
    cyc = 0;
    while (!ack0 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("hold_first_ack", {31'd0, ack0}, 32'd1);
    @(negedge clk);
    check("hold_idle_ack", {31'd0, ack0}, 32'd0);
    @(negedge clk);
    check("hold_2nd_read", {31'd0, mem_read}, 32'd1);
    check("hold_2nd_addr", mem_address, 32'd9);
    req0 = 1'b0;
    @(negedge clk);
    check("hold_2nd_ack", {31'd0, ack0}, 32'd1);
    check("hold_2nd_data", rdata0, 32'hA500_0009);
    @(negedge clk);
    @(negedge clk);
    check("hold_no_3rd", {30'd0, mem_read, ack0}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
